// File: rtl/alu32_arbiter.sv
// Two-requester round-robin front end for the shared 32-bit add/sub ALU.
// One operation is in flight at a time: IDLE accepts, EXEC computes, RESP holds the result.
module alu32_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_sub,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_sub,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_carry,
    output logic             resp_zero,
    output logic             resp_overflow,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    localparam logic [1:0] stIdle = 2'd0;
    localparam logic [1:0] stExec = 2'd1;
    localparam logic [1:0] stResp = 2'd2;

    logic [1:0]       state;
    logic             lastGrant;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             opSub;
    logic             opId;
    logic [WIDTH-1:0] resultQ;
    logic             carryQ;
    logic             zeroQ;
    logic             overflowQ;
    logic             idQ;
    logic [CNT_W-1:0] opsDone;

    logic             grantValid;
    logic             grantId;
    logic             accept;
    logic [WIDTH-1:0] bEff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sumResult;
    logic             sumOverflow;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        grantValid = req0_valid | req1_valid;
        grantId    = (req0_valid && req1_valid) ? ~lastGrant : ~req0_valid;
        accept     = (state == stIdle) && grantValid;
        req0_ready = accept && !grantId;
        req1_ready = accept && grantId;
    end

    always_comb begin
        bEff        = opB ^ {WIDTH{opSub}};
        sum         = {1'b0, opA} + {1'b0, bEff} + {{WIDTH{1'b0}}, opSub};
        sumResult   = sum[WIDTH-1:0];
        sumOverflow = (opA[WIDTH-1] == bEff[WIDTH-1]) && (sumResult[WIDTH-1] != opA[WIDTH-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= stIdle;
            lastGrant <= 1'b1;
            opA       <= '0;
            opB       <= '0;
            opSub     <= 1'b0;
            opId      <= 1'b0;
            resultQ   <= '0;
            carryQ    <= 1'b0;
            zeroQ     <= 1'b0;
            overflowQ <= 1'b0;
            idQ       <= 1'b0;
            opsDone   <= '0;
        end else begin
            case (state)
                stIdle: begin
                    if (accept) begin
                        opA       <= grantId ? req1_a : req0_a;
                        opB       <= grantId ? req1_b : req0_b;
                        opSub     <= grantId ? req1_sub : req0_sub;
                        opId      <= grantId;
                        lastGrant <= grantId;
                        state     <= stExec;
                    end
                end
                stExec: begin
                    resultQ   <= sumResult;
                    carryQ    <= sum[WIDTH];
                    zeroQ     <= ~|sumResult;
                    overflowQ <= sumOverflow;
                    idQ       <= opId;
                    state     <= stResp;
                end
                stResp: begin
                    if (resp_ready) begin
                        opsDone <= opsDone + CNT_W'(1);
                        state   <= stIdle;
                    end
                end
                default: state <= stIdle;
            endcase
        end
    end

    assign resp_valid    = (state == stResp);
    assign resp_id       = idQ;
    assign resp_result   = resultQ;
    assign resp_carry    = carryQ;
    assign resp_zero     = zeroQ;
    assign resp_overflow = overflowQ;
    assign busy          = (state != stIdle);
    assign ops_done      = opsDone;

endmodule

// File: tb/tb_alu32_arbiter.sv
// Directed bench for alu32_arbiter: arithmetic flags, round-robin order, stall and reset.
module tb_alu32_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic        req0_ready;
    logic        req0_sub;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic        req1_sub;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [31:0] resp_result;
    logic        resp_carry;
    logic        resp_zero;
    logic        resp_overflow;
    logic        busy;
    logic [15:0] ops_done;

    int tests;
    int fails;

    alu32_arbiter #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_sub(req0_sub),
        .req0_a(req0_a),
        .req0_b(req0_b),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_sub(req1_sub),
        .req1_a(req1_a),
        .req1_b(req1_b),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_id(resp_id),
        .resp_result(resp_result),
        .resp_carry(resp_carry),
        .resp_zero(resp_zero),
        .resp_overflow(resp_overflow),
        .busy(busy),
        .ops_done(ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req0_sub = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_sub = 1'b0; req1_a = '0; req1_b = '0;
        resp_ready = 1'b1;
        #2;
        tests++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_async valid=%b busy=%b expected 0 0", resp_valid, busy);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (ops_done !== 16'd0 || resp_result !== 32'd0 || resp_id !== 1'b0) begin
            fails++;
            $display("FAIL reset_values ops=%0d res=%h id=%b expected 0 0 0",
                     ops_done, resp_result, resp_id);
        end
        tests++;
        if ({resp_carry, resp_zero, resp_overflow} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags czo=%b expected 000", {resp_carry, resp_zero, resp_overflow});
        end
        tests++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready r0=%b r1=%b expected 0 0", req0_ready, req1_ready);
        end
    endtask

    // Single unopposed request with resp_ready high; checks every stage of the latency.
    task automatic run_op(input string nm, input logic id, input logic sub,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expRes, input logic expC, input logic expZ,
                          input logic expO, input logic [15:0] expOps);
        @(negedge clk);
        resp_ready = 1'b1;
        req0_valid = !id; req0_sub = sub; req0_a = a; req0_b = b;
        req1_valid = id;  req1_sub = sub; req1_a = a; req1_b = b;
        #1;
        tests++;
        if (req0_ready !== !id || req1_ready !== id) begin
            fails++;
            $display("FAIL %s accept_ready r0=%b r1=%b expected %b %b",
                     nm, req0_ready, req1_ready, !id, id);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tests++;
        if (busy !== 1'b1 || resp_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s exec busy=%b valid=%b r0=%b r1=%b expected 1 0 0 0",
                     nm, busy, resp_valid, req0_ready, req1_ready);
        end
        @(negedge clk);
        tests++;
        if (resp_valid !== 1'b1 || resp_id !== id || resp_result !== expRes) begin
            fails++;
            $display("FAIL %s resp valid=%b id=%b res=%h expected 1 %b %h",
                     nm, resp_valid, resp_id, resp_result, id, expRes);
        end
        tests++;
        if ({resp_carry, resp_zero, resp_overflow} !== {expC, expZ, expO}) begin
            fails++;
            $display("FAIL %s flags czo=%b expected %b",
                     nm, {resp_carry, resp_zero, resp_overflow}, {expC, expZ, expO});
        end
        @(negedge clk);
        tests++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || ops_done !== expOps) begin
            fails++;
            $display("FAIL %s done valid=%b busy=%b ops=%0d expected 0 0 %0d",
                     nm, resp_valid, busy, ops_done, expOps);
        end
    endtask

    task automatic test_arith();
        run_op("add_ovf", 1'b0, 1'b0, 32'h7FFFFFFF, 32'h00000001,
               32'h80000000, 1'b0, 1'b0, 1'b1, 16'd1);
        run_op("sub_zero", 1'b1, 1'b1, 32'd5, 32'd5,
               32'h00000000, 1'b1, 1'b1, 1'b0, 16'd2);
        run_op("sub_ovf", 1'b0, 1'b1, 32'h80000000, 32'h00000001,
               32'h7FFFFFFF, 1'b1, 1'b0, 1'b1, 16'd3);
        run_op("add_wrap", 1'b0, 1'b0, 32'hFFFFFFFF, 32'h00000001,
               32'h00000000, 1'b1, 1'b1, 1'b0, 16'd4);
    endtask

    // req0: 1 + 2 = 3, req1: 10 - 3 = 7; both held valid throughout.
    task automatic test_fairness();
        int cnt;
        logic expId;
        logic [31:0] expRes;
        test_reset();
        @(negedge clk);
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_sub = 1'b0; req0_a = 32'd1;  req0_b = 32'd2;
        req1_valid = 1'b1; req1_sub = 1'b1; req1_a = 32'd10; req1_b = 32'd3;
        #1;
        for (int k = 0; k < 4; k++) begin
            expId = k[0];
            expRes = expId ? 32'd7 : 32'd3;
            cnt = 0;
            while (!(req0_ready || req1_ready) && cnt < 10) begin
                @(negedge clk);
                cnt++;
            end
            tests++;
            if (cnt >= 10 || req0_ready !== !expId || req1_ready !== expId) begin
                fails++;
                $display("FAIL rr_grant%0d r0=%b r1=%b expected %b %b",
                         k, req0_ready, req1_ready, !expId, expId);
            end
            @(negedge clk);
            tests++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                fails++;
                $display("FAIL rr_exec_ready%0d r0=%b r1=%b expected 0 0", k, req0_ready, req1_ready);
            end
            @(negedge clk);
            tests++;
            if (resp_valid !== 1'b1 || resp_id !== expId || resp_result !== expRes ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                fails++;
                $display("FAIL rr_resp%0d valid=%b id=%b res=%h r0=%b r1=%b expected 1 %b %h 0 0",
                         k, resp_valid, resp_id, resp_result, req0_ready, req1_ready, expId, expRes);
            end
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tests++;
        if (ops_done !== 16'd4) begin
            fails++;
            $display("FAIL rr_ops ops=%0d expected 4", ops_done);
        end
    endtask

    task automatic test_backpressure_reset();
        @(negedge clk);
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_sub = 1'b0; req0_a = 32'd3; req0_b = 32'd4;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_sub = 1'b0; req1_a = 32'd9; req1_b = 32'd9;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            tests++;
            if (resp_valid !== 1'b1 || resp_result !== 32'd7 || resp_id !== 1'b0 ||
                busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                fails++;
                $display("FAIL stall%0d valid=%b res=%h id=%b busy=%b r0=%b r1=%b expected 1 7 0 1 0 0",
                         k, resp_valid, resp_result, resp_id, busy, req0_ready, req1_ready);
            end
            @(negedge clk);
        end
        tests++;
        if (ops_done !== 16'd4) begin
            fails++;
            $display("FAIL stall_ops ops=%0d expected 4", ops_done);
        end
        #1 rst = 1'b1;
        #1;
        tests++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || ops_done !== 16'd0) begin
            fails++;
            $display("FAIL mid_reset valid=%b busy=%b ops=%0d expected 0 0 0",
                     resp_valid, busy, ops_done);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_grant r0=%b r1=%b expected 0 1", req0_ready, req1_ready);
        end
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        run_op("recover", 1'b0, 1'b1, 32'd2, 32'd3,
               32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 16'd1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_arith();
        test_fairness();
        test_backpressure_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
